mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one N-bit mux4 datapath between four requesters (a, b, c, d) and drives the mux select.
- Each requester presents a word and holds req high. The arbiter grants one requester at a time and streams its words to a single consumer through a valid/ready handshake.
- A grant ends when the owner drops req or hits the burst limit.
- Sits in front of any shared bus or register-file write port in the machine.

Parameters:
- N, 8, data width of each input word and of out_data.
- MAX_BURST, 4, maximum transfers per grant; 0 = unlimited. Counter width is clog2(MAX_BURST)+1, minimum 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  4  request per source; bit0=a, bit1=b, bit2=c, bit3=d
- in_a, in_b, in_c, in_d  in  N each  source data words
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  N  mux4 output selected by sel
- out_valid  out  1  out_data is a valid word from the granted source
- sel  out  2  registered mux select, index of current/last owner
- gnt  out  4  registered one-hot grant; 0 when idle
- ack  out  4  one-hot pulse: owner's word consumed this cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, sel=0, ptr=0, burst_cnt=0. Consequently out_valid=0 and ack=0 immediately. A transfer in flight is discarded with no ack.
- State machine: IDLE, GRANT. Registered two-state encoding.
- Round-robin search: the winner is the first set bit of req, scanning from index ptr upward modulo 4 (3 wraps to 0).
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, on the next edge: sel<=winner, gnt<=onehot(winner), burst_cnt<=0, state<=GRANT.
  - Latency from req rising to gnt is 1 cycle.
- GRANT combinational outputs:
  - out_valid = req[sel].
  - xfer = out_valid & out_ready.
  - ack = onehot(sel) when xfer, else 0.
- On each xfer edge, burst_cnt increments.
- Release condition, evaluated each GRANT cycle: req[sel]==0, OR (xfer AND MAX_BURST!=0 AND burst_cnt==MAX_BURST-1).
- On release (back-to-back handoff, no bubble):
  - ptr<=sel+1 (mod 4).
  - Re-arbitrate over the current req, scanning from sel+1. The owner is included only as lowest priority.
  - If a winner exists: sel<=winner, gnt<=onehot(winner), burst_cnt<=0, stay in GRANT.
  - If no winner: gnt<=0, state<=IDLE. sel holds its value.
- Burst limit with no other requester: the same owner is re-granted with burst_cnt=0. It sees one continuous gnt, and ack continues.
- out_ready low: no xfer, burst_cnt holds, grant holds indefinitely while req[sel]=1. No timeout.
- Owner drops req in the same cycle out_ready rises: no xfer, release.
- out_data is always mux4(in_a..in_d, sel), including when out_valid=0. Consumers ignore it unless out_valid.
- Requesters sample ack to advance their data. Data must stay stable while req is high and ack is not yet seen.
- req changes on non-owners never disturb an active grant.

Decomposition:
- Shared header mr_defs.vh holds:
  - state localparams (ST_IDLE=1'b0, ST_GRANT=1'b1)
  - a function rr_pick(req, start) returning {found, idx[1:0]}.
- One sub-module: the existing mux4 (parameter N). Its in_a..in_d connect straight through, sel comes from the arbiter register, and out feeds out_data.
- Everything else is in the arbiter module.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> gnt=0, out_valid=0, ack=0, sel=0. Drop rst_n mid-GRANT -> gnt=0 immediately, no ack.
- Single requester, MAX_BURST=4:
  - Setup: in_c=8'hA0, req=4'b0100, out_ready=1 for 6 cycles.
  - Expected: gnt=4'b0100 1 cycle after req, sel=2, out_data=A0.
  - ack[2] pulses every cycle; burst limit re-grants to c with no gnt gap.
- Round-robin order:
  - Setup: in_a=AA, in_b=00, in_c=A0, in_d=0A. req=4'b1111 held, MAX_BURST=1, out_ready=1.
  - Expected: sel sequence 0,1,2,3,0; out_data AA,00,A0,0A,AA; one ack per cycle.
- Backpressure:
  - Setup: owner b, out_ready=0 for 3 cycles, then 1.
  - Expected: out_valid=1 and ack=0 while stalled, burst_cnt unchanged, gnt stays 4'b0010, ack[1] on the first ready cycle.
- Owner drop / handoff:
  - Setup: a owns, req goes 4'b1001 -> 4'b1000.
  - Expected: next edge gnt=4'b1000, sel=3, no idle cycle. Then req=0 -> IDLE, gnt=0, sel stays 3.
- Wrap and unlimited burst:
  - Setup: MAX_BURST=0, d owns with 10 transfers while req[0] is also high.
  - Expected: gnt stays 4'b1000 for all 10. After d drops, a is granted and ptr wraps to 0.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter:
// FSM state encoding and the rotating first-set-bit search.
package mux4_rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   // First set bit of req, scanning upward from start and wrapping 3 -> 0.
   function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] start);
      pick_t      p;
      logic [1:0] k;
      p.found = 1'b0;
      p.idx   = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         k = start + 2'(i);
         if (!p.found && req[k]) begin
            p.found = 1'b1;
            p.idx   = k;
         end
      end
      return p;
   endfunction

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle for the shared mux4 arbiter.
// master = requesters and consumer, slave = the arbiter.
interface mux4_rr_arbiter_if #(
   parameter int N = 8
);
   logic [3:0]   req;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic [N-1:0] in_c;
   logic [N-1:0] in_d;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic         out_valid;
   logic [1:0]   sel;
   logic [3:0]   gnt;
   logic [3:0]   ack;

   modport master (
      output req, in_a, in_b, in_c, in_d, out_ready,
      input  out_data, out_valid, sel, gnt, ack
   );

   modport slave (
      input  req, in_a, in_b, in_c, in_d, out_ready,
      output out_data, out_valid, sel, gnt, ack
   );
endinterface

// File: rtl/mux4_rr_arbiter_mux4.sv
// Plain N-bit 4:1 multiplexer shared by the arbiter's requesters.
module mux4 #(
   parameter int N = 8
) (
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic [N-1:0] in_c,
   input  logic [N-1:0] in_d,
   input  logic [1:0]   sel,
   output logic [N-1:0] out
);

   always_comb begin
      out = in_a;
      case (sel)
         2'd0:    out = in_a;
         2'd1:    out = in_b;
         2'd2:    out = in_c;
         2'd3:    out = in_d;
         default: out = in_a;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux4 between four requesters; streams the
// owner's words through a valid/ready handshake with an optional burst limit.
module mux4_rr_arbiter #(
   parameter int N         = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mux4_rr_arbiter_if.slave  bus
);
   import mux4_rr_arbiter_pkg::*;

   localparam int            CW      = $clog2(MAX_BURST) + 1;
   localparam bit            LIMITED = (MAX_BURST != 0);
   localparam logic [CW-1:0] LAST    = CW'(MAX_BURST - 1);

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_sel,   w_sel_nxt;
   logic [1:0]    r_ptr,   w_ptr_nxt;
   logic [3:0]    r_gnt,   w_gnt_nxt;
   logic [CW-1:0] r_burst, w_burst_nxt;

   logic          w_out_valid;
   logic          w_xfer;
   logic          w_release;
   logic [1:0]    w_start;
   pick_t         w_pick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_burst <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
         r_burst <= w_burst_nxt;
      end
   end

   // Searching from sel+1 while granted leaves the current owner last in line.
   always_comb begin
      w_out_valid = (r_state == ST_GRANT) && bus.req[r_sel];
      w_xfer      = w_out_valid && bus.out_ready;
      w_release   = (r_state == ST_GRANT) &&
                    (!bus.req[r_sel] || (w_xfer && LIMITED && (r_burst == LAST)));
      w_start     = (r_state == ST_GRANT) ? (r_sel + 2'd1) : r_ptr;
      w_pick      = rr_pick(bus.req, w_start);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = r_gnt;
      w_burst_nxt = r_burst;
      case (r_state)
         ST_IDLE: begin
            if (w_pick.found) begin
               w_state_nxt = ST_GRANT;
               w_sel_nxt   = w_pick.idx;
               w_gnt_nxt   = onehot4(w_pick.idx);
               w_burst_nxt = '0;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               w_ptr_nxt = r_sel + 2'd1;
               if (w_pick.found) begin
                  w_sel_nxt   = w_pick.idx;
                  w_gnt_nxt   = onehot4(w_pick.idx);
                  w_burst_nxt = '0;
               end else begin
                  w_gnt_nxt   = '0;
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_xfer) begin
               w_burst_nxt = r_burst + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      bus.out_valid = w_out_valid;
      bus.ack       = w_xfer ? onehot4(r_sel) : '0;
      bus.sel       = r_sel;
      bus.gnt       = r_gnt;
   end

   mux4 #(.N(N)) u_mux4 (
      .in_a (bus.in_a),
      .in_b (bus.in_b),
      .in_c (bus.in_c),
      .in_d (bus.in_d),
      .sel  (r_sel),
      .out  (bus.out_data)
   );

   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(r_gnt));
   a_gnt_matches_sel : assert property (@(posedge clk) disable iff (!rst_n)
      (r_gnt != '0) |-> (r_gnt == onehot4(r_sel)));
   a_ack_within_gnt : assert property (@(posedge clk) disable iff (!rst_n)
      (bus.ack & ~r_gnt) == '0);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed scoreboard bench for mux4_rr_arbiter at MAX_BURST = 4, 1 and 0.
module tb_mux4_rr_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux4_rr_arbiter_if #(.N(8)) if4 ();
   mux4_rr_arbiter_if #(.N(8)) if1 ();
   mux4_rr_arbiter_if #(.N(8)) if0 ();

   mux4_rr_arbiter #(.N(8), .MAX_BURST(4)) u_b4 (.clk(clk), .rst_n(rst_n), .bus(if4));
   mux4_rr_arbiter #(.N(8), .MAX_BURST(1)) u_b1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   mux4_rr_arbiter #(.N(8), .MAX_BURST(0)) u_b0 (.clk(clk), .rst_n(rst_n), .bus(if0));

   // Expected {ack, out_data} per accepted word, one queue per instance.
   logic [11:0] q4[$];
   logic [11:0] q1[$];
   logic [11:0] q0[$];
   logic [11:0] e4, e1, e0;
   logic [7:0]  rr_data [4] = '{8'hAA, 8'h00, 8'hA0, 8'h0A};

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (if4.ack !== 4'b0000) begin
         if (q4.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL mon4_unexpected: got ack %b data %h expected no ack", if4.ack, if4.out_data);
         end else begin
            e4 = q4.pop_front();
            chk("mon4_ack_data", {if4.ack, if4.out_data}, e4);
         end
      end
   end

   always @(negedge clk) begin
      if (if1.ack !== 4'b0000) begin
         if (q1.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL mon1_unexpected: got ack %b data %h expected no ack", if1.ack, if1.out_data);
         end else begin
            e1 = q1.pop_front();
            chk("mon1_ack_data", {if1.ack, if1.out_data}, e1);
         end
      end
   end

   always @(negedge clk) begin
      if (if0.ack !== 4'b0000) begin
         if (q0.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL mon0_unexpected: got ack %b data %h expected no ack", if0.ack, if0.out_data);
         end else begin
            e0 = q0.pop_front();
            chk("mon0_ack_data", {if0.ack, if0.out_data}, e0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      if4.req = '0; if4.in_a = '0; if4.in_b = '0; if4.in_c = '0; if4.in_d = '0; if4.out_ready = 1'b0;
      if1.req = '0; if1.in_a = '0; if1.in_b = '0; if1.in_c = '0; if1.in_d = '0; if1.out_ready = 1'b0;
      if0.req = '0; if0.in_a = '0; if0.in_b = '0; if0.in_c = '0; if0.in_d = '0; if0.out_ready = 1'b0;

      // Reset holds everything quiet even with all requests up.
      if4.req = 4'b1111; if4.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_gnt",   if4.gnt,       4'b0000);
      chk("rst_valid", if4.out_valid, 1'b0);
      chk("rst_ack",   if4.ack,       4'b0000);
      chk("rst_sel",   if4.sel,       2'd0);
      if4.req = '0; if4.out_ready = 1'b0;
      tick();
      rst_n = 1'b1;

      // Single requester c, burst limit 4, 6 transfers with no gnt gap.
      if4.in_c = 8'hA0; if4.req = 4'b0100; if4.out_ready = 1'b1;
      repeat (6) q4.push_back({4'b0100, 8'hA0});
      @(negedge clk);
      chk("single_lat_gnt", if4.gnt, 4'b0000);
      tick();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("single_gnt",  if4.gnt,      4'b0100);
         chk("single_sel",  if4.sel,      2'd2);
         chk("single_data", if4.out_data, 8'hA0);
         tick();
      end
      if4.req = '0;
      @(negedge clk);
      chk("single_drop_valid", if4.out_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("single_idle_gnt", if4.gnt, 4'b0000);
      chk("single_idle_sel", if4.sel, 2'd2);

      // Round-robin rotation with burst limit 1.
      if1.in_a = 8'hAA; if1.in_b = 8'h00; if1.in_c = 8'hA0; if1.in_d = 8'h0A;
      if1.req = 4'b1111; if1.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) q1.push_back({4'b0001 << (i % 4), rr_data[i % 4]});
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_sel",  if1.sel,      i % 4);
         chk("rr_data", if1.out_data, rr_data[i % 4]);
         tick();
      end
      if1.req = '0;
      tick();
      @(negedge clk);
      chk("rr_idle_gnt", if1.gnt, 4'b0000);

      // Backpressure on owner b.
      if4.in_b = 8'h5B; if4.req = 4'b0010; if4.out_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", if4.out_valid, 1'b1);
         chk("bp_ack",   if4.ack,       4'b0000);
         chk("bp_gnt",   if4.gnt,       4'b0010);
         tick();
      end
      if4.out_ready = 1'b1;
      q4.push_back({4'b0010, 8'h5B});
      @(negedge clk);
      chk("bp_ready_gnt", if4.gnt, 4'b0010);
      tick();
      if4.req = '0; if4.out_ready = 1'b0;
      tick();
      @(negedge clk);
      chk("bp_idle_gnt", if4.gnt, 4'b0000);

      // Owner a drops while d waits: handoff without an idle cycle.
      if4.in_a = 8'h11; if4.in_d = 8'hDD; if4.req = 4'b0001; if4.out_ready = 1'b1;
      tick();
      q4.push_back({4'b0001, 8'h11});
      @(negedge clk);
      chk("hand_gnt_a0", if4.gnt, 4'b0001);
      tick();
      if4.req = 4'b1001;
      q4.push_back({4'b0001, 8'h11});
      @(negedge clk);
      chk("hand_gnt_a1", if4.gnt, 4'b0001);
      tick();
      if4.req = 4'b1000;
      @(negedge clk);
      chk("hand_drop_valid", if4.out_valid, 1'b0);
      tick();
      q4.push_back({4'b1000, 8'hDD});
      @(negedge clk);
      chk("hand_gnt_d", if4.gnt, 4'b1000);
      chk("hand_sel_d", if4.sel, 2'd3);
      tick();
      if4.req = '0;
      @(negedge clk);
      chk("hand_drop_valid_d", if4.out_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("hand_idle_gnt", if4.gnt, 4'b0000);
      chk("hand_idle_sel", if4.sel, 2'd3);

      // Unlimited burst: d keeps the grant while a waits, then pointer wraps to a.
      if0.in_d = 8'h5C; if0.in_a = 8'h3E; if0.req = 4'b1000; if0.out_ready = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         if (i == 1) if0.req = 4'b1001;
         q0.push_back({4'b1000, 8'h5C});
         @(negedge clk);
         chk("unl_gnt_d", if0.gnt, 4'b1000);
         tick();
      end
      if0.req = 4'b0011;
      @(negedge clk);
      chk("unl_drop_valid", if0.out_valid, 1'b0);
      tick();
      q0.push_back({4'b0001, 8'h3E});
      @(negedge clk);
      chk("unl_wrap_gnt", if0.gnt, 4'b0001);
      chk("unl_wrap_sel", if0.sel, 2'd0);
      tick();
      if0.req = '0;
      tick();
      @(negedge clk);
      chk("unl_idle_gnt", if0.gnt, 4'b0000);

      // Asynchronous reset in the middle of a grant.
      if1.in_c = 8'h77; if1.req = 4'b0100; if1.out_ready = 1'b0;
      tick();
      @(negedge clk);
      chk("arst_pre_gnt", if1.gnt, 4'b0100);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      if1.out_ready = 1'b1;
      #1;
      chk("arst_gnt",   if1.gnt,       4'b0000);
      chk("arst_ack",   if1.ack,       4'b0000);
      chk("arst_valid", if1.out_valid, 1'b0);
      if1.req = '0;
      tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);

      chk("q4_drained", q4.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q0_drained", q0.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
